imm_encoder: RTL
================

Name: imm_encoder

Overview:
- Streaming immediate encoder; the inverse of the decode-side immediate generator.
- Takes an instruction template, a 32-bit immediate and an immediate-format code, and scatters the immediate bits into the RISC-V instruction fields.
- Flags immediates that the chosen format cannot represent.
- Sits in the self-test / instruction-injection path: a sequencer feeds it, and its output drives instruction memory writes or a loader.
- Two-stage valid/ready pipeline with full backpressure.

Parameters:
WIDTH, 32, instruction/immediate width (only 32 supported)
CNT_W, 16, width of saturating error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream item valid
in_ready  output  1  block can accept item this cycle
in_immsrc  input  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101-111 illegal
in_imm  input  WIDTH  immediate value (byte offset for B/J; full upper value for U)
in_base  input  WIDTH  instruction template; bits not owned by the format pass through unchanged
out_valid  output  1  encoded instruction valid
out_ready  input  1  downstream accepts
out_instr  output  WIDTH  encoded instruction
out_err  output  1  item was not representable or format illegal
err_count  output  CNT_W  saturating count of errored items delivered
clr_count  input  1  synchronous clear of err_count

Behaviour:
- Reset (rst_n low, asynchronous): both stage valids 0, out_valid 0, out_instr 0, out_err 0, err_count 0.
- Reset mid-operation drops all in-flight items; no partial output is emitted.
- Pipeline: stage S1 registers {immsrc, imm, base}; stage S2 registers {instr, err}. Outputs come from S2.
  - Latency is 2 cycles from input handshake to out_valid with no stall.
- Handshake:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational, no bubble).
  - Throughput is 1 item/cycle while out_ready = 1.
  - Items are never dropped or duplicated; order is preserved.
  - out_instr and out_err stay stable while out_valid & !out_ready.
- Field mapping (bits not listed are copied from base):
  - I: [31:20] = imm[11:0].
  - S: [31:25] = imm[11:5]; [11:7] = imm[4:0].
  - B: [31] = imm[12]; [7] = imm[11]; [30:25] = imm[10:5]; [11:8] = imm[4:1].
  - J: [31] = imm[20]; [19:12] = imm[19:12]; [20] = imm[11]; [30:21] = imm[10:1].
  - U: [31:12] = imm[31:12].
- Error computation (S1 -> S2):
  - I, S: err if imm != sign-extend(imm[11:0]).
  - B: err if imm != sign-extend(imm[12:0]) or imm[0] = 1.
  - J: err if imm != sign-extend(imm[20:0]) or imm[0] = 1.
  - U: err if imm[11:0] != 0.
  - Illegal immsrc: err = 1 and instr = base unchanged.
- On error the truncated encoding (per the mapping above) is still emitted with out_err = 1.
- Round-trip invariant: when out_err = 0, decoding out_instr with the same immsrc reproduces in_imm exactly.
- err_count:
  - Increments by 1 on out_valid & out_ready & out_err.
  - Saturates at all-ones.
  - clr_count sets it to 0 on the next edge; clear wins over a simultaneous increment.

Test Plan:
- Reset: assert rst_n=0 with S1/S2 full -> out_valid=0, err_count=0 immediately, and no output after release until a new input arrives.
- I-type: base=0x00000013, immsrc=000, imm=0xFFFFF800 (-2048) -> out_instr=0x80000013, out_err=0, two cycles after acceptance. Then imm=0x00000800 -> out_err=1, err_count=1.
- B-type: base=0x00000063, imm=0xFFFFF000 (-4096) -> out_instr=0x80000063, out_err=0. Then imm=0x00000003 -> out_err=1 (odd offset).
- J/U: J base=0x0000006F, imm=0x000FFFFE -> out_instr=0x7FFFF06F. U base=0x00000037, imm=0x12345000 -> out_instr=0x12345037. U with imm=0x12345001 -> out_err=1.
- Backpressure: stream 6 items with out_ready toggling 1,0,0,1 -> all 6 emitted in order with no loss. in_ready=0 only when both stages are full and out_ready=0. Output stays stable during stalls.
- Counter: 3 illegal-immsrc items (instr=base) -> err_count=3. clr_count pulsed in the same cycle as a 4th errored delivery -> err_count=0. Force CNT_W=2 and send 5 errors -> count holds at 3.

Source files
------------

// File: rtl/imm_encoder.sv
// Streaming RISC-V immediate encoder: scatters a 32-bit immediate into the
// I/S/B/J/U fields of an instruction template and flags unrepresentable values.
module imm_encoder #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_immsrc,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [WIDTH-1:0] in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_count
);

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_U = 3'b100;

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_immsrc_q, s1_immsrc_d;
    logic [WIDTH-1:0] s1_imm_q, s1_imm_d;
    logic [WIDTH-1:0] s1_base_q, s1_base_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_instr_q, s2_instr_d;
    logic             s2_err_q, s2_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] enc_instr;
    logic             enc_err;

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high. The producer holds valid and its payload until that edge; ready may
    // depend combinationally on the downstream ready, never on valid.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Field scatter and range check for the item sitting in S1.
    always_comb begin
        enc_instr = s1_base_q;
        enc_err   = 1'b0;
        case (s1_immsrc_q)
            FMT_I: begin
                enc_instr[31:20] = s1_imm_q[11:0];
                enc_err          = s1_imm_q[31:11] != {21{s1_imm_q[11]}};
            end
            FMT_S: begin
                enc_instr[31:25] = s1_imm_q[11:5];
                enc_instr[11:7]  = s1_imm_q[4:0];
                enc_err          = s1_imm_q[31:11] != {21{s1_imm_q[11]}};
            end
            FMT_B: begin
                enc_instr[31]    = s1_imm_q[12];
                enc_instr[7]     = s1_imm_q[11];
                enc_instr[30:25] = s1_imm_q[10:5];
                enc_instr[11:8]  = s1_imm_q[4:1];
                enc_err          = (s1_imm_q[31:12] != {20{s1_imm_q[12]}}) || s1_imm_q[0];
            end
            FMT_J: begin
                enc_instr[31]    = s1_imm_q[20];
                enc_instr[19:12] = s1_imm_q[19:12];
                enc_instr[20]    = s1_imm_q[11];
                enc_instr[30:21] = s1_imm_q[10:1];
                enc_err          = (s1_imm_q[31:20] != {12{s1_imm_q[20]}}) || s1_imm_q[0];
            end
            FMT_U: begin
                enc_instr[31:12] = s1_imm_q[31:12];
                enc_err          = s1_imm_q[11:0] != 12'h000;
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
    end

    // Payload registers only load when a valid item moves in, so held outputs stay stable.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_immsrc_d = s1_immsrc_q;
        s1_imm_d    = s1_imm_q;
        s1_base_d   = s1_base_q;
        s2_valid_d  = s2_valid_q;
        s2_instr_d  = s2_instr_q;
        s2_err_d    = s2_err_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_immsrc_d = in_immsrc;
                s1_imm_d    = in_imm;
                s1_base_d   = in_base;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_d = enc_instr;
                s2_err_d   = enc_err;
            end
        end
    end

    // Clear takes priority over a same-cycle errored delivery.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (s2_valid_q && out_ready && s2_err_q && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_immsrc_q <= '0;
            s1_imm_q    <= '0;
            s1_base_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_instr_q  <= '0;
            s2_err_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_immsrc_q <= s1_immsrc_d;
            s1_imm_q    <= s1_imm_d;
            s1_base_q   <= s1_base_d;
            s2_valid_q  <= s2_valid_d;
            s2_instr_q  <= s2_instr_d;
            s2_err_q    <= s2_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_instr = s2_instr_q;
    assign out_err   = s2_err_q;
    assign err_count = cnt_q;

endmodule
